cursor_controller: RTL and testbench
====================================

CURSOR_CONTROLLER -- requirements
Module: cursor_controller

Interface
REQ-001 Parameter GRID_W, default 8, board columns.
REQ-002 Parameter GRID_H, default 8, board rows.
REQ-003 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for reveal_ack.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 up_valid, down_valid, left_valid, right_valid, center_valid  input  1 each  single-cycle debounced button pulses.
REQ-007 game_active  input  1  high while play is allowed.
REQ-008 cur_x  output  clog2(GRID_W)  registered cursor column.
REQ-009 cur_y  output  clog2(GRID_H)  registered cursor row.
REQ-010 reveal_req  output  1  request to board logic to reveal (reveal_x, reveal_y).
REQ-011 reveal_x, reveal_y  output  same widths as cur_x/cur_y  latched reveal coordinates.
REQ-012 reveal_ack  input  1  board logic accepts the reveal.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on handshake abort.
REQ-015 move_count  output  16  saturating count of accepted cursor moves.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, DONE.
REQ-017 In IDLE with game_active high, the block SHALL service at most one pulse per cycle, priority center > up > down > left > right; lower-priority pulses in the same cycle are discarded, not queued.
REQ-018 An up pulse SHALL decrement cur_y, down increment cur_y, left decrement cur_x, right increment cur_x, updating on the next edge (1-cycle latency).
REQ-019 Movement SHALL saturate at 0 and GRID_W-1 / GRID_H-1; no wrap-around; a saturated move does not change the cursor and does not increment move_count.
REQ-020 Each accepted move that changes the cursor SHALL increment move_count by 1, holding at 16'hFFFF.
REQ-021 A center pulse in IDLE SHALL latch cur_x/cur_y into reveal_x/reveal_y and enter REQ on the next edge.
REQ-022 In REQ, reveal_req SHALL be high and reveal_x/reveal_y stable until reveal_ack is sampled high.
REQ-023 reveal_ack sampled high in REQ SHALL move the FSM to DONE; reveal_req is low from the following cycle.
REQ-024 DONE SHALL last exactly one cycle and return to IDLE.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each REQ cycle; reaching ACK_TIMEOUT without ack SHALL assert timeout_err for one cycle and go to DONE.
REQ-026 Ack and timeout in the same cycle SHALL count as ack; timeout_err stays low.
REQ-027 All button pulses arriving in REQ or DONE SHALL be ignored.
REQ-028 game_active low in IDLE SHALL ignore all pulses; game_active falling during REQ SHALL NOT abort the handshake.
REQ-029 reveal_ack outside REQ SHALL be ignored.

Reset
REQ-030 Asserting rst_n low SHALL, asynchronously and at any point including mid-handshake, force state IDLE, cur_x=0, cur_y=0, reveal_x=0, reveal_y=0, reveal_req=0, busy=0, timeout_err=0, move_count=0, wait counter=0.
REQ-031 The first cycle after rst_n rises SHALL accept pulses normally.

Structure
REQ-032 GRID_W, GRID_H, coordinate widths, ACK_TIMEOUT default and the state encoding SHALL live in the shared minesweeper package/header used by the board and VGA blocks.
REQ-033 The block SHALL be a single module with no sub-modules; the debounced pulses come from the existing controller block.

Verification
REQ-034 Reset, then 3 right and 2 down pulses -> cur_x=3, cur_y=2, move_count=5.
REQ-035 At cur_x=0, left pulse; at cur_x=7, right pulse -> cursor unchanged, move_count unchanged.
REQ-036 Center and up in the same cycle at (3,2) -> reveal_req next cycle with (3,2); cur_y stays 2; up pulse during REQ ignored.
REQ-037 Center, ack after 4 cycles -> reveal_req high 4 cycles, low the cycle after ack, busy low 2 cycles after ack.
REQ-038 Center with no ack, ACK_TIMEOUT=16 -> timeout_err pulses once at cycle 16 of REQ, FSM back to IDLE next cycle.
REQ-039 rst_n low during REQ -> reveal_req and all outputs 0 immediately, without waiting for a clk edge; a late ack is ignored.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board geometry, handshake timeout default and
// the cursor FSM encoding used by the cursor, board and VGA blocks.
package minesweeper_pkg;

    localparam int MS_GRID_W      = 8;
    localparam int MS_GRID_H      = 8;
    localparam int MS_X_W         = $clog2(MS_GRID_W);
    localparam int MS_Y_W         = $clog2(MS_GRID_H);
    localparam int MS_ACK_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } cur_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cursor_controller.sv
// Board cursor: moves on debounced button pulses, saturating at the edges, and
// issues a reveal request/ack handshake with timeout on the center button.
module cursor_controller
    import minesweeper_pkg::*;
#(
    parameter int GRID_W      = MS_GRID_W,
    parameter int GRID_H      = MS_GRID_H,
    parameter int ACK_TIMEOUT = MS_ACK_TIMEOUT,
    localparam int XW         = $clog2(GRID_W),
    localparam int YW         = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic          down_valid,
    input  logic          left_valid,
    input  logic          right_valid,
    input  logic          center_valid,
    input  logic          game_active,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          reveal_req,
    output logic [XW-1:0] reveal_x,
    output logic [YW-1:0] reveal_y,
    input  logic          reveal_ack,
    output logic          busy,
    output logic          timeout_err,
    output logic [15:0]   move_count
);

    localparam int WW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(ACK_TIMEOUT - 1);

    cur_state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d, rx_q, rx_d;
    logic [YW-1:0] y_q, y_d, ry_q, ry_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          terr_q, terr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        terr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only the highest-priority pulse is looked at; if it saturates,
                // the lower ones are still dropped.
                if (game_active) begin
                    if (center_valid) begin
                        rx_d    = x_q;
                        ry_d    = y_q;
                        wait_d  = '0;
                        state_d = ST_REQ;
                    end else if (up_valid) begin
                        if (y_q != '0) begin
                            y_d   = y_q - 1'b1;
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end else if (down_valid) begin
                        if (y_q != Y_MAX) begin
                            y_d   = y_q + 1'b1;
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end else if (left_valid) begin
                        if (x_q != '0) begin
                            x_d   = x_q - 1'b1;
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end else if (right_valid) begin
                        if (x_q != X_MAX) begin
                            x_d   = x_q + 1'b1;
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end
                end
            end
            ST_REQ: begin
                // Ack wins over a coincident timeout.
                if (reveal_ack) begin
                    state_d = ST_DONE;
                end else if (wait_q == WAIT_END) begin
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cur_x       = x_q;
    assign cur_y       = y_q;
    assign reveal_x    = rx_q;
    assign reveal_y    = ry_q;
    assign move_count  = cnt_q;
    assign timeout_err = terr_q;
    assign reveal_req  = (state_q == ST_REQ);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with a scoreboard queue of expected values.
module tb_cursor_controller;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic       game_active, reveal_ack;
    logic [2:0] cur_x, cur_y, reveal_x, reveal_y;
    logic       reveal_req, busy, timeout_err;
    logic [15:0] move_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hi_cnt;

    cursor_controller #(.GRID_W(8), .GRID_H(8), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(btn[3]), .down_valid(btn[2]), .left_valid(btn[1]),
        .right_valid(btn[0]), .center_valid(btn[4]),
        .game_active(game_active),
        .cur_x(cur_x), .cur_y(cur_y),
        .reveal_req(reveal_req), .reveal_x(reveal_x), .reveal_y(reveal_y),
        .reveal_ack(reveal_ack), .busy(busy), .timeout_err(timeout_err),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_v(input string tag, input logic [31:0] v);
        sbq.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_all_zero(input string where);
        for (int i = 0; i < 9; i++) exp_v({where, "_zero"}, 32'd0);
        chk(32'(cur_x));      chk(32'(cur_y));
        chk(32'(reveal_x));   chk(32'(reveal_y));
        chk(32'(reveal_req)); chk(32'(busy));
        chk(32'(timeout_err)); chk(32'(move_count));
        chk(32'(dut.wait_q));
    endtask

    // Drive one pulse pattern for one cycle and check the cursor after the edge.
    task automatic press(input logic [4:0] b, input int ex, input int ey, input int ec);
        btn = b;
        exp_v("cur_x", 32'(ex));
        exp_v("cur_y", 32'(ey));
        exp_v("move_count", 32'(ec));
        tick();
        btn = '0;
        chk(32'(cur_x));
        chk(32'(cur_y));
        chk(32'(move_count));
    endtask

    initial begin
        btn = '0; game_active = 1'b1; reveal_ack = 1'b0; rst_n = 1'b0;
        #3;
        chk_all_zero("reset_async");

        // First cycle after reset release accepts pulses; 3 right, 2 down.
        @(negedge clk);
        rst_n = 1'b1;
        press(B_R, 1, 0, 1);
        press(B_R, 2, 0, 2);
        press(B_R, 3, 0, 3);
        press(B_D, 3, 1, 4);
        press(B_D, 3, 2, 5);

        // Center + up together at (3,2); up during REQ ignored.
        btn = B_C | B_U;
        exp_v("req_enter", 1); exp_v("reveal_x", 3); exp_v("reveal_y", 2);
        exp_v("cur_y_hold", 2); exp_v("busy_req", 1);
        tick(); btn = '0;
        chk(32'(reveal_req)); chk(32'(reveal_x)); chk(32'(reveal_y));
        chk(32'(cur_y)); chk(32'(busy));
        btn = B_U;
        exp_v("req_hold", 1); exp_v("cur_y_in_req", 2); exp_v("reveal_y_stable", 2);
        tick(); btn = '0;
        chk(32'(reveal_req)); chk(32'(cur_y)); chk(32'(reveal_y));
        reveal_ack = 1'b1;
        exp_v("req_after_ack", 0); exp_v("busy_done", 1);
        tick(); reveal_ack = 1'b0;
        chk(32'(reveal_req)); chk(32'(busy));
        exp_v("busy_idle", 0);
        tick();
        chk(32'(busy));

        // Ack arriving during the 4th REQ cycle.
        btn = B_C; tick(); btn = '0;
        hi_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (reveal_req) hi_cnt++;
            if (i == 3) reveal_ack = 1'b1;
            tick();
        end
        reveal_ack = 1'b0;
        exp_v("req_high_cycles", 4); exp_v("req_low_after_ack", 0); exp_v("busy_done4", 1);
        chk(32'(hi_cnt)); chk(32'(reveal_req)); chk(32'(busy));
        exp_v("busy_low_2_after", 0);
        tick();
        chk(32'(busy));

        // Edge saturation on all four sides.
        press(B_L, 2, 2, 6);
        press(B_L, 1, 2, 7);
        press(B_L, 0, 2, 8);
        press(B_L, 0, 2, 8);
        for (int i = 1; i <= 7; i++) press(B_R, i, 2, 8 + i);
        press(B_R, 7, 2, 15);
        press(B_U, 7, 1, 16);
        press(B_U, 7, 0, 17);
        press(B_U, 7, 0, 17);
        for (int i = 1; i <= 7; i++) press(B_D, 7, i, 17 + i);
        press(B_D, 7, 7, 24);

        // Priority and discard of lower pulses.
        press(B_U | B_L, 7, 6, 25);
        press(B_L | B_R, 6, 6, 26);
        press(B_D | B_L | B_R, 6, 7, 27);
        press(B_D | B_R, 6, 7, 27);

        // game_active low ignores everything, including center.
        game_active = 1'b0;
        press(B_L, 6, 7, 27);
        btn = B_C;
        exp_v("inactive_no_req", 0); exp_v("inactive_not_busy", 0);
        tick(); btn = '0;
        chk(32'(reveal_req)); chk(32'(busy));
        game_active = 1'b1;

        // Stray ack in IDLE.
        reveal_ack = 1'b1;
        exp_v("ack_idle_busy", 0); exp_v("ack_idle_req", 0);
        tick(); reveal_ack = 1'b0;
        chk(32'(busy)); chk(32'(reveal_req));

        // Timeout after 16 REQ cycles; game_active dropping mid-handshake does not abort.
        btn = B_C; tick(); btn = '0;
        exp_v("to_reveal_x", 6); exp_v("to_reveal_y", 7);
        chk(32'(reveal_x)); chk(32'(reveal_y));
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) game_active = 1'b0;
            exp_v("to_req_hold", 1); exp_v("to_err_early", 0);
            chk(32'(reveal_req)); chk(32'(timeout_err));
            tick();
        end
        exp_v("to_req_c16", 1); exp_v("to_err_c16", 0);
        chk(32'(reveal_req)); chk(32'(timeout_err));
        tick();
        exp_v("to_err_pulse", 1); exp_v("to_req_low", 0); exp_v("to_busy_done", 1);
        chk(32'(timeout_err)); chk(32'(reveal_req)); chk(32'(busy));
        tick();
        exp_v("to_err_one_cycle", 0); exp_v("to_busy_idle", 0);
        chk(32'(timeout_err)); chk(32'(busy));
        game_active = 1'b1;

        // Ack coincident with timeout counts as ack.
        btn = B_C; tick(); btn = '0;
        for (int i = 1; i <= 15; i++) tick();
        reveal_ack = 1'b1;
        exp_v("ack_to_err", 0); exp_v("ack_to_busy", 1); exp_v("ack_to_req", 0);
        tick(); reveal_ack = 1'b0;
        chk(32'(timeout_err)); chk(32'(busy)); chk(32'(reveal_req));
        tick();

        // Asynchronous reset in the middle of REQ; late ack ignored.
        btn = B_C; tick(); btn = '0;
        exp_v("pre_rst_req", 1);
        chk(32'(reveal_req));
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_req");
        reveal_ack = 1'b1;
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_v("late_ack_busy", 0); exp_v("late_ack_req", 0);
        chk(32'(busy)); chk(32'(reveal_req));
        reveal_ack = 1'b0;
        press(B_D, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
